hilo_mul_unit: RTL and testbench

HILO_MUL_UNIT -- requirements
Module: hilo_mul_unit

---
 rtl/hilo_mul_unit.sv | 134 +++++++++++++
 tb/tb_hilo_mul_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_mul_unit.sv
// HI/LO shift-add multiplier with GPIO port.
// Iterative 32-step multiply into HI/LO; combinational read mux.
module hilo_mul_unit #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enhilo,
  input  logic [3:0]    alu_op,
  input  logic [DW-1:0] op_a,
  input  logic [DW-1:0] op_b,
  input  logic [1:0]    regsel,
  input  logic          gpio_in_en,
  input  logic          gpio_out_en,
  input  logic [DW-1:0] gpio_wdata,
  input  logic [DW-1:0] gpio_in,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic          stall,
  output logic          done,
  output logic [DW-1:0] gpio_out
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {IDLE, MUL} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [DW-1:0]   mcand;
  logic [DW-1:0]   mplr;
  logic [2*DW-1:0] acc;
  logic            neg;
  logic [DW-1:0]   hi;
  logic [DW-1:0]   lo;
  logic [DW-1:0]   gpio_s1;
  logic [DW-1:0]   gpio_sync;

  logic            is_s;
  logic            start;
  logic [DW-1:0]   abs_a;
  logic [DW-1:0]   abs_b;
  logic [2*DW-1:0] addend;
  logic [2*DW-1:0] acc_nxt;
  logic [2*DW-1:0] prod;

  // Operand conditioning and one shift-add step of the datapath
  always_comb begin
    is_s    = (alu_op == 4'b0110);
    start   = enhilo & (is_s | (alu_op == 4'b0111));
    abs_a   = (is_s & op_a[DW-1]) ? -op_a : op_a;
    abs_b   = (is_s & op_b[DW-1]) ? -op_b : op_b;
    addend  = '0;
    if (mplr[0])
      addend = {{DW{1'b0}}, mcand} << count;
    acc_nxt = acc + addend;
    prod    = neg ? -acc_nxt : acc_nxt;
  end

  // Multiply FSM: accept in IDLE, iterate DW steps in MUL, write HI/LO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mcand <= abs_a;
            mplr  <= abs_b;
            acc   <= '0;
            neg   <= is_s & (op_a[DW-1] ^ op_b[DW-1]);
            count <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc   <= acc_nxt;
          mplr  <= mplr >> 1;
          count <= count + CW'(1);
          if (count == LAST) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
            count    <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-flop synchronizer for the external input pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_s1   <= '0;
      gpio_sync <= '0;
    end else begin
      gpio_s1   <= gpio_in;
      gpio_sync <= gpio_s1;
    end
  end

  // Output pin register, written independently of the multiplier
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      gpio_out <= '0;
    else if (gpio_out_en)
      gpio_out <= gpio_wdata;
  end

  // Status flags and the read-data priority mux
  always_comb begin
    busy  = (state == MUL);
    stall = busy & (enhilo | (regsel == 2'b01) | (regsel == 2'b10));
    rd_data = '0;
    if (gpio_in_en)
      rd_data = gpio_sync;
    else if (regsel == 2'b01)
      rd_data = hi;
    else if (regsel == 2'b10)
      rd_data = lo;
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Testbench for hilo_mul_unit.
// Table of multiply vectors plus directed stall/reset/GPIO sequences.
module tb_hilo_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        enhilo;
  logic [3:0]  alu_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [1:0]  regsel;
  logic        gpio_in_en;
  logic        gpio_out_en;
  logic [31:0] gpio_wdata;
  logic [31:0] gpio_in;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] gpio_out;

  int checks = 0;
  int errors = 0;

  hilo_mul_unit #(.DW(32)) dut (
    .clk(clk), .rst(rst), .enhilo(enhilo), .alu_op(alu_op),
    .op_a(op_a), .op_b(op_b), .regsel(regsel),
    .gpio_in_en(gpio_in_en), .gpio_out_en(gpio_out_en),
    .gpio_wdata(gpio_wdata), .gpio_in(gpio_in),
    .rd_data(rd_data), .busy(busy), .stall(stall), .done(done),
    .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic read_hilo(input string nm, input logic [31:0] ehi,
                           input logic [31:0] elo);
    regsel = 2'b01;
    #1 chk({nm, "_hi"}, 64'(rd_data), 64'(ehi));
    regsel = 2'b10;
    #1 chk({nm, "_lo"}, 64'(rd_data), 64'(elo));
    regsel = 2'b00;
  endtask

  task automatic do_mul(input vec_t v);
    int bc;
    bit got;
    @(negedge clk);
    enhilo = 1'b1;
    alu_op = v.sgn ? 4'b0110 : 4'b0111;
    op_a   = v.a;
    op_b   = v.b;
    @(negedge clk);
    enhilo = 1'b0;
    op_a   = 32'hDEAD_BEEF;
    op_b   = 32'h0BAD_F00D;
    chk({v.name, "_busy"}, 64'(busy), 64'd1);
    bc  = 1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
    end
    chk({v.name, "_done_seen"}, 64'(got), 64'd1);
    chk({v.name, "_busy_cycles"}, 64'(bc), 64'd32);
    chk({v.name, "_idle_at_done"}, 64'(busy), 64'd0);
    read_hilo(v.name, v.hi, v.lo);
    @(negedge clk);
    chk({v.name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bc;
    bit got;
    int dseen;

    vecs[0] = '{1'b0, 32'd7, 32'd6, 32'h0, 32'h2A, "multu_7x6"};
    vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'd5,
                32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5"};
    vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000,
                32'h4000_0000, 32'h0, "mult_min_sq"};
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFE, 32'h1, "multu_max_sq"};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h0, 32'h1, "mult_m1xm1"};
    vecs[5] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA,
                32'h0, 32'h2A, "mult_m7xm6"};
    vecs[6] = '{1'b0, 32'h0001_0000, 32'h0001_0000,
                32'h1, 32'h0, "multu_2p32"};
    vecs[7] = '{1'b1, 32'd0, 32'h8000_0000,
                32'h0, 32'h0, "mult_zero"};

    rst         = 1'b1;
    enhilo      = 1'b0;
    alu_op      = 4'b0000;
    op_a        = '0;
    op_b        = '0;
    regsel      = 2'b00;
    gpio_in_en  = 1'b0;
    gpio_out_en = 1'b0;
    gpio_wdata  = '0;
    gpio_in     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd", 64'(rd_data), 64'd0);
    chk("rst_gpio_out", 64'(gpio_out), 64'd0);
    read_hilo("rst", 32'h0, 32'h0);

    // Non-multiply alu_op must not start the FSM
    enhilo = 1'b1;
    alu_op = 4'b0010;
    @(negedge clk);
    enhilo = 1'b0;
    chk("bad_op_no_start", 64'(busy), 64'd0);

    foreach (vecs[i]) do_mul(vecs[i]);

    // Read and re-request while busy: stall, old LO, no restart
    @(negedge clk);
    enhilo = 1'b1;
    alu_op = 4'b0111;
    op_a   = 32'h0000_1234;
    op_b   = 32'h0000_0010;
    @(negedge clk);
    enhilo = 1'b0;
    #1 chk("st_no_stall_idle_req", 64'(stall), 64'd0);
    bc  = 1;
    got = 1'b0;
    for (int k = 1; k < 100; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      if (k == 4) regsel = 2'b10;
      if (k >= 6 && k <= 8) begin
        enhilo = 1'b1;
        alu_op = 4'b0110;
        op_a   = 32'd9;
        op_b   = 32'd9;
      end else begin
        enhilo = 1'b0;
      end
      #1;
      if (k == 4)
        chk("st_old_lo", 64'(rd_data), 64'(vecs[7].lo));
      if (k == 7 || k == 4)
        chk("st_stall_on", 64'(stall), 64'd1);
      if (k == 3)
        chk("st_stall_off", 64'(stall), 64'd0);
    end
    chk("st_done_seen", 64'(got), 64'd1);
    chk("st_busy_cycles", 64'(bc), 64'd32);
    #1 chk("st_stall_at_done", 64'(stall), 64'd0);
    chk("st_new_lo", 64'(rd_data), 64'h0001_2340);
    bc = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("st_no_restart", 64'(bc), 64'd0);
    regsel = 2'b00;
    read_hilo("st", 32'h0, 32'h0001_2340);

    // Reset mid-multiply aborts and clears HI/LO
    @(negedge clk);
    enhilo = 1'b1;
    alu_op = 4'b0111;
    op_a   = 32'd7;
    op_b   = 32'd6;
    @(negedge clk);
    enhilo = 1'b0;
    repeat (10) @(negedge clk);
    chk("rm_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1 chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_done", 64'(done), 64'd0);
    read_hilo("rm", 32'h0, 32'h0);
    @(negedge clk);
    rst   = 1'b0;
    dseen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy) dseen++;
    end
    chk("rm_no_done", 64'(dseen), 64'd0);
    read_hilo("rm_after", 32'h0, 32'h0);

    // GPIO output latch and hold
    @(negedge clk);
    gpio_out_en = 1'b1;
    gpio_wdata  = 32'hA5A5_A5A5;
    @(negedge clk);
    chk("gpio_out_load", 64'(gpio_out), 64'hA5A5_A5A5);
    gpio_out_en = 1'b0;
    gpio_wdata  = 32'h1111_2222;
    @(negedge clk);
    chk("gpio_out_hold", 64'(gpio_out), 64'hA5A5_A5A5);

    // GPIO input synchronizer latency and read priority
    gpio_in    = 32'h1234_5678;
    gpio_in_en = 1'b1;
    regsel     = 2'b01;
    #1 chk("gpio_in_0edge", 64'(rd_data), 64'h0);
    @(negedge clk);
    chk("gpio_in_1edge", 64'(rd_data), 64'h0);
    @(negedge clk);
    chk("gpio_in_2edge", 64'(rd_data), 64'h1234_5678);
    gpio_in_en = 1'b0;
    regsel     = 2'b00;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
